// File: rtl/uart_buffers_param_if.sv
// Bus between the UART buffering stage and its neighbours: the APB register
// file on one side and the TX/RX shift registers on the other. The slave
// modport is the buffer stage; the master modport is whatever drives it.
interface uart_buffers_param_if #(
  parameter int DATA_W    = 8,
  parameter int DEPTH_LOG = 4
);
  logic                fifoen;
  logic                txclr;
  logic                rxclr;
  logic [1:0]          rxfiftl;
  logic                thr_wr_en;
  logic [DATA_W-1:0]   pwdata;
  logic                tsr_load;
  logic [DATA_W-1:0]   tx_data;
  logic                tx_empty;
  logic                tx_full;
  logic [DEPTH_LOG:0]  tx_count;
  logic                receive_done;
  logic [DATA_W-1:0]   rsr_data;
  logic                break_int;
  logic                frame_error;
  logic                parity_error;
  logic                rbr_rd_en;
  logic [DATA_W+2:0]   rbr;
  logic                rx_empty;
  logic                rx_full;
  logic [DEPTH_LOG:0]  rx_count;
  logic                rx_trigger;
  logic                rx_fifo_err;
  logic                overrun;
  logic                ovr_clr;
  logic                char_tick;
  logic                rx_timeout;

  modport master (
    output fifoen, txclr, rxclr, rxfiftl, thr_wr_en, pwdata, tsr_load,
           receive_done, rsr_data, break_int, frame_error, parity_error,
           rbr_rd_en, ovr_clr, char_tick,
    input  tx_data, tx_empty, tx_full, tx_count, rbr, rx_empty, rx_full,
           rx_count, rx_trigger, rx_fifo_err, overrun, rx_timeout
  );

  modport slave (
    input  fifoen, txclr, rxclr, rxfiftl, thr_wr_en, pwdata, tsr_load,
           receive_done, rsr_data, break_int, frame_error, parity_error,
           rbr_rd_en, ovr_clr, char_tick,
    output tx_data, tx_empty, tx_full, tx_count, rbr, rx_empty, rx_full,
           rx_count, rx_trigger, rx_fifo_err, overrun, rx_timeout
  );
endinterface

// File: rtl/uart_buffers_param.sv
// TX/RX buffering between the APB register file and the UART shift registers.
// FIFO mode holds DEPTH entries; holding mode behaves as a single THR/RBR.
// RX entries carry {break, frame, parity, data}. A running count of errored
// entries drives rx_fifo_err; overrun is sticky until ovr_clr.
// Optional feature macro: UART_BUF_TIMEOUT_EN (RX character timeout on
// char_tick). Without it rx_timeout is tied low and char_tick is ignored.
module uart_buffers_param #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int DEPTH_LOG = 4,
  parameter int TO_CHARS  = 4
) (
  input  logic                  pclk,
  input  logic                  presetn,
  uart_buffers_param_if.slave   bus
);

  localparam int CW = DEPTH_LOG + 1;
  localparam logic [DEPTH_LOG-1:0] PTR_ONE = 1;
  localparam logic [CW-1:0]        CNT_ONE = 1;
  localparam logic [CW-1:0]        LVL_1   = 1;
  localparam logic [CW-1:0]        LVL_Q   = CW'(DEPTH / 4);
  localparam logic [CW-1:0]        LVL_H   = CW'(DEPTH / 2);
  localparam logic [CW-1:0]        LVL_F   = CW'(DEPTH - 2);

  // ---------------- mode tracking ----------------
  logic          r_fifoen;
  logic          w_mode_chg;
  logic [CW-1:0] w_cap;

  assign w_mode_chg = bus.fifoen ^ r_fifoen;
  assign w_cap      = bus.fifoen ? CW'(DEPTH) : CNT_ONE;

  // Remember the last mode so a change can flush both buffers
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) r_fifoen <= 1'b0;
    else          r_fifoen <= bus.fifoen;
  end

  // ---------------- TX buffer ----------------
  logic [DATA_W-1:0]    r_tx_mem [DEPTH];
  logic [DEPTH_LOG-1:0] r_tx_wr_ptr;
  logic [DEPTH_LOG-1:0] r_tx_rd_ptr;
  logic [CW-1:0]        r_tx_count;
  logic                 w_tx_empty;
  logic                 w_tx_full;
  logic                 w_tx_clr;
  logic                 w_tx_pop;
  logic                 w_tx_push;

  assign w_tx_empty = (r_tx_count == '0);
  assign w_tx_full  = (r_tx_count == w_cap);
  assign w_tx_clr   = bus.txclr | w_mode_chg;
  assign w_tx_pop   = bus.tsr_load & ~w_tx_empty;
  // A pop on a full buffer frees the slot for a same-cycle push
  assign w_tx_push  = bus.thr_wr_en & (~w_tx_full | w_tx_pop);

  // TX pointers and occupancy; clear wins over push/pop
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_tx_wr_ptr <= '0;
      r_tx_rd_ptr <= '0;
      r_tx_count  <= '0;
    end else if (w_tx_clr) begin
      r_tx_wr_ptr <= '0;
      r_tx_rd_ptr <= '0;
      r_tx_count  <= '0;
    end else begin
      if (w_tx_push) r_tx_wr_ptr <= r_tx_wr_ptr + PTR_ONE;
      if (w_tx_pop)  r_tx_rd_ptr <= r_tx_rd_ptr + PTR_ONE;
      if (w_tx_push && !w_tx_pop)      r_tx_count <= r_tx_count + CNT_ONE;
      else if (!w_tx_push && w_tx_pop) r_tx_count <= r_tx_count - CNT_ONE;
    end
  end

  // TX storage write (data only, no reset needed: reads are gated by empty)
  always_ff @(posedge pclk) begin
    if (w_tx_push && !w_tx_clr) r_tx_mem[r_tx_wr_ptr] <= bus.pwdata;
  end

  assign bus.tx_data  = w_tx_empty ? '0 : r_tx_mem[r_tx_rd_ptr];
  assign bus.tx_empty = w_tx_empty;
  assign bus.tx_full  = w_tx_full;
  assign bus.tx_count = r_tx_count;

  // ---------------- RX buffer ----------------
  logic [DATA_W+2:0]    r_rx_mem [DEPTH];
  logic [DEPTH_LOG-1:0] r_rx_wr_ptr;
  logic [DEPTH_LOG-1:0] r_rx_rd_ptr;
  logic [CW-1:0]        r_rx_count;
  logic [CW-1:0]        r_err_cnt;
  logic                 r_overrun;
  logic                 w_rx_empty;
  logic                 w_rx_full;
  logic                 w_rx_clr;
  logic                 w_rx_pop;
  logic                 w_rx_push;
  logic                 w_rx_ovr_evt;
  logic                 w_rx_ovw;
  logic [DEPTH_LOG-1:0] w_rx_wr_idx;
  logic [DATA_W+2:0]    w_rx_entry;
  logic                 w_new_err;
  logic                 w_head_err;
  logic                 w_err_inc;
  logic                 w_err_dec;

  assign w_rx_empty   = (r_rx_count == '0);
  assign w_rx_full    = (r_rx_count == w_cap);
  assign w_rx_clr     = bus.rxclr | w_mode_chg;
  assign w_rx_pop     = bus.rbr_rd_en & ~w_rx_empty;
  assign w_rx_push    = bus.receive_done & (~w_rx_full | w_rx_pop);
  // Character arriving with no room: flags overrun unless a clear swallows it
  assign w_rx_ovr_evt = bus.receive_done & w_rx_full & ~w_rx_pop & ~w_rx_clr;
  // Holding mode replaces the single RBR entry instead of dropping
  assign w_rx_ovw     = w_rx_ovr_evt & ~bus.fifoen;
  assign w_rx_wr_idx  = w_rx_ovw ? r_rx_rd_ptr : r_rx_wr_ptr;
  assign w_rx_entry   = {bus.break_int, bus.frame_error, bus.parity_error, bus.rsr_data};
  assign w_new_err    = bus.break_int | bus.frame_error | bus.parity_error;
  assign w_head_err   = |r_rx_mem[r_rx_rd_ptr][DATA_W+2:DATA_W];
  assign w_err_inc    = (w_rx_push | w_rx_ovw) & w_new_err;
  assign w_err_dec    = (w_rx_pop | w_rx_ovw) & w_head_err;

  // RX pointers, occupancy and errored-entry count; clear wins
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_rx_wr_ptr <= '0;
      r_rx_rd_ptr <= '0;
      r_rx_count  <= '0;
      r_err_cnt   <= '0;
    end else if (w_rx_clr) begin
      r_rx_wr_ptr <= '0;
      r_rx_rd_ptr <= '0;
      r_rx_count  <= '0;
      r_err_cnt   <= '0;
    end else begin
      if (w_rx_push) r_rx_wr_ptr <= r_rx_wr_ptr + PTR_ONE;
      if (w_rx_pop)  r_rx_rd_ptr <= r_rx_rd_ptr + PTR_ONE;
      if (w_rx_push && !w_rx_pop)      r_rx_count <= r_rx_count + CNT_ONE;
      else if (!w_rx_push && w_rx_pop) r_rx_count <= r_rx_count - CNT_ONE;
      r_err_cnt <= r_err_cnt + CW'(w_err_inc) - CW'(w_err_dec);
    end
  end

  // RX storage write, including the holding-mode overwrite of the head
  always_ff @(posedge pclk) begin
    if ((w_rx_push || w_rx_ovw) && !w_rx_clr) r_rx_mem[w_rx_wr_idx] <= w_rx_entry;
  end

  // Sticky overrun; a new event beats a same-cycle ovr_clr
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn)         r_overrun <= 1'b0;
    else if (w_rx_ovr_evt) r_overrun <= 1'b1;
    else if (bus.ovr_clr)  r_overrun <= 1'b0;
  end

  // Map the trigger select onto a depth-scaled level
  logic [CW-1:0] w_level;
  always_comb begin
    w_level = LVL_1;
    case (bus.rxfiftl)
      2'b00:   w_level = LVL_1;
      2'b01:   w_level = LVL_Q;
      2'b10:   w_level = LVL_H;
      default: w_level = LVL_F;
    endcase
  end

  assign bus.rbr         = w_rx_empty ? '0 : r_rx_mem[r_rx_rd_ptr];
  assign bus.rx_empty    = w_rx_empty;
  assign bus.rx_full     = w_rx_full;
  assign bus.rx_count    = r_rx_count;
  assign bus.rx_trigger  = bus.fifoen ? (r_rx_count >= w_level) : ~w_rx_empty;
  assign bus.rx_fifo_err = (r_err_cnt != '0);
  assign bus.overrun     = r_overrun;

  // ---------------- RX character timeout ----------------
`ifdef UART_BUF_TIMEOUT_EN
  localparam int TW = $clog2(TO_CHARS + 1);
  localparam logic [TW-1:0] TO_LIM = TW'(TO_CHARS);

  logic [TW-1:0] r_to_cnt;

  function automatic logic [TW-1:0] sat_inc(input logic [TW-1:0] v);
    return (v >= TO_LIM) ? v : v + TW'(1);
  endfunction

  // Count idle character times while RX holds data in FIFO mode
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_to_cnt <= '0;
    end else if (w_rx_clr || bus.receive_done || bus.rbr_rd_en || w_rx_empty) begin
      r_to_cnt <= '0;
    end else if (bus.char_tick && bus.fifoen) begin
      r_to_cnt <= sat_inc(r_to_cnt);
    end
  end

  assign bus.rx_timeout = (r_to_cnt >= TO_LIM);
`else
  logic w_unused;
  assign w_unused       = bus.char_tick ^ (TO_CHARS == 0);
  assign bus.rx_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_buffers_param.sv
// Directed bench for uart_buffers_param (DATA_W=8, DEPTH=16).
// Build with +define+UART_BUF_TIMEOUT_EN to exercise the RX timeout.
module tb_uart_buffers_param;

  logic pclk;
  logic presetn;
  int   errors;
  int   checks;

  uart_buffers_param_if #(.DATA_W(8), .DEPTH_LOG(4)) bus ();

  uart_buffers_param #(
    .DATA_W(8), .DEPTH(16), .DEPTH_LOG(4), .TO_CHARS(4)
  ) dut (
    .pclk    (pclk),
    .presetn (presetn),
    .bus     (bus)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // Advance one clock; inputs change and outputs are sampled 1 after the edge
  task automatic cyc();
    @(posedge pclk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.txclr = 0; bus.rxclr = 0; bus.rxfiftl = 2'b00;
    bus.thr_wr_en = 0; bus.pwdata = '0; bus.tsr_load = 0;
    bus.receive_done = 0; bus.rsr_data = '0;
    bus.break_int = 0; bus.frame_error = 0; bus.parity_error = 0;
    bus.rbr_rd_en = 0; bus.ovr_clr = 0; bus.char_tick = 0;
  endtask

  task automatic rx_push(input logic [7:0] d, input logic [2:0] e);
    bus.receive_done = 1; bus.rsr_data = d;
    {bus.break_int, bus.frame_error, bus.parity_error} = e;
    cyc();
    bus.receive_done = 0;
    {bus.break_int, bus.frame_error, bus.parity_error} = 3'b000;
  endtask

  task automatic rx_pop();
    bus.rbr_rd_en = 1; cyc(); bus.rbr_rd_en = 0;
  endtask

  task automatic rx_clear();
    bus.rxclr = 1; cyc(); bus.rxclr = 0;
  endtask

  task automatic test_reset();
    presetn = 0;
    idle_inputs();
    bus.fifoen = 1;
    #2;
    checks++;
    if ({bus.tx_empty, bus.rx_empty} !== 2'b11) begin
      errors++; $display("FAIL reset_empty: got %b want 11", {bus.tx_empty, bus.rx_empty});
    end
    checks++;
    if ({bus.tx_full, bus.rx_full, bus.rx_trigger, bus.rx_fifo_err, bus.overrun, bus.rx_timeout} !== 6'b0) begin
      errors++; $display("FAIL reset_flags: got %b want 000000",
        {bus.tx_full, bus.rx_full, bus.rx_trigger, bus.rx_fifo_err, bus.overrun, bus.rx_timeout});
    end
    checks++;
    if (bus.tx_count !== 5'd0 || bus.rx_count !== 5'd0) begin
      errors++; $display("FAIL reset_counts: got tx=%0d rx=%0d want 0 0", bus.tx_count, bus.rx_count);
    end
    checks++;
    if (bus.tx_data !== 8'h00 || bus.rbr !== 11'h000) begin
      errors++; $display("FAIL reset_data: got tx=%h rbr=%h want 00 000", bus.tx_data, bus.rbr);
    end
    cyc(); cyc();
    presetn = 1;
    cyc(); cyc();
  endtask

  task automatic test_tx_fifo();
    for (int i = 0; i < 16; i++) begin
      bus.thr_wr_en = 1; bus.pwdata = 8'(8'h11 + i); cyc();
    end
    bus.thr_wr_en = 0;
    checks++;
    if (bus.tx_full !== 1'b1 || bus.tx_count !== 5'd16) begin
      errors++; $display("FAIL tx_fill: got full=%b count=%0d want 1 16", bus.tx_full, bus.tx_count);
    end
    bus.thr_wr_en = 1; bus.pwdata = 8'hAA; cyc(); bus.thr_wr_en = 0;
    checks++;
    if (bus.tx_count !== 5'd16 || bus.tx_data !== 8'h11) begin
      errors++; $display("FAIL tx_drop_on_full: got count=%0d head=%h want 16 11", bus.tx_count, bus.tx_data);
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (bus.tx_data !== 8'(8'h11 + i)) begin
        errors++; $display("FAIL tx_order[%0d]: got %h want %h", i, bus.tx_data, 8'(8'h11 + i));
      end
      bus.tsr_load = 1; cyc();
    end
    bus.tsr_load = 0;
    checks++;
    if (bus.tx_empty !== 1'b1 || bus.tx_data !== 8'h00) begin
      errors++; $display("FAIL tx_drain: got empty=%b data=%h want 1 00", bus.tx_empty, bus.tx_data);
    end
    bus.tsr_load = 1; cyc(); bus.tsr_load = 0;
    checks++;
    if (bus.tx_count !== 5'd0) begin
      errors++; $display("FAIL tx_pop_empty: got count=%0d want 0", bus.tx_count);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      bus.thr_wr_en = 1; bus.pwdata = 8'(8'hA0 + i); cyc();
    end
    bus.thr_wr_en = 1; bus.pwdata = 8'hA3; bus.tsr_load = 1; cyc();
    bus.thr_wr_en = 0; bus.tsr_load = 0;
    checks++;
    if (bus.tx_count !== 5'd3 || bus.tx_data !== 8'hA1) begin
      errors++; $display("FAIL tx_push_pop: got count=%0d head=%h want 3 a1", bus.tx_count, bus.tx_data);
    end
    bus.txclr = 1; bus.thr_wr_en = 1; bus.pwdata = 8'hEE; cyc();
    bus.txclr = 0; bus.thr_wr_en = 0;
    checks++;
    if (bus.tx_empty !== 1'b1 || bus.tx_count !== 5'd0) begin
      errors++; $display("FAIL tx_clear: got empty=%b count=%0d want 1 0", bus.tx_empty, bus.tx_count);
    end
  endtask

  task automatic test_rx_trigger();
    bus.rxfiftl = 2'b01;
    rx_push(8'h31, 3'b000); rx_push(8'h32, 3'b000); rx_push(8'h33, 3'b000);
    checks++;
    if (bus.rx_trigger !== 1'b0 || bus.rx_count !== 5'd3) begin
      errors++; $display("FAIL trig_below: got trig=%b count=%0d want 0 3", bus.rx_trigger, bus.rx_count);
    end
    rx_push(8'h34, 3'b000);
    checks++;
    if (bus.rx_trigger !== 1'b1) begin
      errors++; $display("FAIL trig_reach: got %b want 1", bus.rx_trigger);
    end
    rx_pop();
    checks++;
    if (bus.rx_trigger !== 1'b0 || bus.rbr !== 11'h032) begin
      errors++; $display("FAIL trig_after_pop: got trig=%b rbr=%h want 0 032", bus.rx_trigger, bus.rbr);
    end
    bus.rxfiftl = 2'b11;
    rx_clear();
  endtask

  task automatic test_rx_overrun();
    for (int i = 0; i < 16; i++) rx_push(8'(8'h80 + i), 3'b000);
    checks++;
    if (bus.rx_full !== 1'b1 || bus.rx_trigger !== 1'b1) begin
      errors++; $display("FAIL rx_fill: got full=%b trig=%b want 1 1", bus.rx_full, bus.rx_trigger);
    end
    bus.ovr_clr = 1;
    rx_push(8'h55, 3'b000);
    bus.ovr_clr = 0;
    checks++;
    if (bus.overrun !== 1'b1 || bus.rx_count !== 5'd16 || bus.rbr !== 11'h080) begin
      errors++; $display("FAIL rx_overrun: got ovr=%b count=%0d rbr=%h want 1 16 080",
        bus.overrun, bus.rx_count, bus.rbr);
    end
    bus.ovr_clr = 1; cyc(); bus.ovr_clr = 0;
    checks++;
    if (bus.overrun !== 1'b0) begin
      errors++; $display("FAIL ovr_clr: got %b want 0", bus.overrun);
    end
    bus.rbr_rd_en = 1;
    rx_push(8'h55, 3'b000);
    bus.rbr_rd_en = 0;
    checks++;
    if (bus.overrun !== 1'b0 || bus.rx_count !== 5'd16 || bus.rbr !== 11'h081) begin
      errors++; $display("FAIL rx_full_push_pop: got ovr=%b count=%0d rbr=%h want 0 16 081",
        bus.overrun, bus.rx_count, bus.rbr);
    end
    for (int i = 0; i < 15; i++) rx_pop();
    checks++;
    if (bus.rbr !== 11'h055 || bus.rx_count !== 5'd1) begin
      errors++; $display("FAIL rx_last: got rbr=%h count=%0d want 055 1", bus.rbr, bus.rx_count);
    end
    rx_pop();
    checks++;
    if (bus.rx_empty !== 1'b1) begin
      errors++; $display("FAIL rx_drain: got %b want 1", bus.rx_empty);
    end
  endtask

  task automatic test_holding();
    bus.fifoen = 0; cyc();
    rx_push(8'h3C, 3'b000);
    checks++;
    if (bus.rx_full !== 1'b1 || bus.rx_trigger !== 1'b1) begin
      errors++; $display("FAIL hold_full: got full=%b trig=%b want 1 1", bus.rx_full, bus.rx_trigger);
    end
    rx_push(8'h4D, 3'b000);
    checks++;
    if (bus.rbr !== 11'h04D || bus.overrun !== 1'b1 || bus.rx_count !== 5'd1) begin
      errors++; $display("FAIL hold_overwrite: got rbr=%h ovr=%b count=%0d want 04d 1 1",
        bus.rbr, bus.overrun, bus.rx_count);
    end
    bus.ovr_clr = 1; cyc(); bus.ovr_clr = 0;
    checks++;
    if (bus.overrun !== 1'b0) begin
      errors++; $display("FAIL hold_ovr_clr: got %b want 0", bus.overrun);
    end
    bus.thr_wr_en = 1; bus.pwdata = 8'h77; cyc();
    bus.pwdata = 8'h88; cyc(); bus.thr_wr_en = 0;
    checks++;
    if (bus.tx_full !== 1'b1 || bus.tx_count !== 5'd1 || bus.tx_data !== 8'h77) begin
      errors++; $display("FAIL hold_tx: got full=%b count=%0d data=%h want 1 1 77",
        bus.tx_full, bus.tx_count, bus.tx_data);
    end
    bus.fifoen = 1; cyc();
    checks++;
    if (bus.rx_empty !== 1'b1 || bus.tx_empty !== 1'b1) begin
      errors++; $display("FAIL mode_change: got rx_empty=%b tx_empty=%b want 1 1", bus.rx_empty, bus.tx_empty);
    end
  endtask

  task automatic test_err_flag();
    rx_push(8'h01, 3'b010);
    rx_push(8'h02, 3'b000);
    rx_push(8'h03, 3'b000);
    checks++;
    if (bus.rx_fifo_err !== 1'b1 || bus.rbr !== 11'h201) begin
      errors++; $display("FAIL err_set: got err=%b rbr=%h want 1 201", bus.rx_fifo_err, bus.rbr);
    end
    rx_pop();
    checks++;
    if (bus.rx_fifo_err !== 1'b0 || bus.rbr !== 11'h002) begin
      errors++; $display("FAIL err_pop: got err=%b rbr=%h want 0 002", bus.rx_fifo_err, bus.rbr);
    end
    rx_push(8'h04, 3'b001);
    checks++;
    if (bus.rx_fifo_err !== 1'b1) begin
      errors++; $display("FAIL err_parity: got %b want 1", bus.rx_fifo_err);
    end
    bus.rxclr = 1;
    rx_push(8'h05, 3'b100);
    bus.rxclr = 0;
    checks++;
    if (bus.rx_count !== 5'd0 || bus.rx_fifo_err !== 1'b0 || bus.rx_empty !== 1'b1) begin
      errors++; $display("FAIL rxclr_push: got count=%0d err=%b empty=%b want 0 0 1",
        bus.rx_count, bus.rx_fifo_err, bus.rx_empty);
    end
  endtask

  task automatic test_timeout();
    logic exp_to;
`ifdef UART_BUF_TIMEOUT_EN
    exp_to = 1'b1;
`else
    exp_to = 1'b0;
`endif
    rx_push(8'h61, 3'b000);
    rx_push(8'h62, 3'b000);
    bus.char_tick = 1; cyc(); cyc(); cyc(); bus.char_tick = 0; cyc();
    checks++;
    if (bus.rx_timeout !== 1'b0) begin
      errors++; $display("FAIL timeout_3ticks: got %b want 0", bus.rx_timeout);
    end
    bus.char_tick = 1; cyc(); bus.char_tick = 0;
    checks++;
    if (bus.rx_timeout !== exp_to) begin
      errors++; $display("FAIL timeout_4ticks: got %b want %b", bus.rx_timeout, exp_to);
    end
    rx_pop();
    checks++;
    if (bus.rx_timeout !== 1'b0 || bus.rx_count !== 5'd1) begin
      errors++; $display("FAIL timeout_read: got to=%b count=%0d want 0 1", bus.rx_timeout, bus.rx_count);
    end
    rx_push(8'h63, 3'b010);
    bus.char_tick = 1; cyc(); cyc(); bus.char_tick = 0;
    presetn = 0;
    #1;
    checks++;
    if ({bus.rx_timeout, bus.rx_fifo_err, bus.overrun, bus.rx_trigger, bus.rx_empty} !== 5'b00001
        || bus.rx_count !== 5'd0) begin
      errors++; $display("FAIL async_reset: got flags=%b count=%0d want 00001 0",
        {bus.rx_timeout, bus.rx_fifo_err, bus.overrun, bus.rx_trigger, bus.rx_empty}, bus.rx_count);
    end
    cyc();
    presetn = 1;
    cyc();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_tx_fifo();
    test_back_to_back();
    test_rx_trigger();
    test_rx_overrun();
    test_holding();
    test_err_flag();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_buffers_param.md
Name: uart_buffers_param

Overview:
Parametrised TX/RX buffering stage between the APB register file and the UART TX/RX shift registers.
- Supports FIFO mode (depth DEPTH) and holding-register mode (single THR/RBR entry).
- Stores per-character error status alongside RX data.
- Adds depth-scaled trigger levels, overrun detection, an RX error-present flag and an optional RX character timeout.

Parameters:
DATA_W, 8, character width in bits
DEPTH, 16, FIFO depth in entries; power of two, at least 4
DEPTH_LOG, 4, log2(DEPTH)
TO_CHARS, 4, character times of RX inactivity before rx_timeout (optional feature only)

Ports:
pclk  input  1  clock; all state on rising edge
presetn  input  1  asynchronous active-low reset
fifoen  input  1  1 = FIFO mode, 0 = holding-register mode
txclr  input  1  synchronous TX buffer clear pulse
rxclr  input  1  synchronous RX buffer clear pulse
rxfiftl  input  2  RX trigger level select
thr_wr_en  input  1  push pwdata into TX buffer
pwdata  input  DATA_W  write data
tsr_load  input  1  pop TX buffer head
tx_data  output  DATA_W  TX head entry
tx_empty  output  1  TX buffer empty
tx_full  output  1  TX buffer full
tx_count  output  DEPTH_LOG+1  TX occupancy
receive_done  input  1  push RX character
rsr_data  input  DATA_W  received character
break_int, frame_error, parity_error  input  1 each  status for the receive_done character
rbr_rd_en  input  1  pop RX buffer head
rbr  output  DATA_W+3  {break, frame, parity, data} of RX head
rx_empty  output  1  RX buffer empty
rx_full  output  1  RX buffer full
rx_count  output  DEPTH_LOG+1  RX occupancy
rx_trigger  output  1  RX level reached
rx_fifo_err  output  1  at least one stored RX entry has a nonzero error field
overrun  output  1  sticky overrun flag
ovr_clr  input  1  clears overrun
char_tick  input  1  one pulse per character time (optional feature only)
rx_timeout  output  1  RX character timeout (optional feature only)

Behaviour:
- Reset: all pointers, counts, holding registers, error counter, overrun and timeout state = 0.
  - Reset outputs: tx_empty = rx_empty = 1; tx_full, rx_full, tx_count, rx_count, rx_trigger, rx_fifo_err, overrun, rx_timeout = 0; tx_data = 0; rbr = 0.
- Effective capacity: DEPTH when fifoen = 1, 1 when fifoen = 0. Full means count equals effective capacity.
- Head visibility: tx_data and rbr show the head entry combinationally. Output is 0 when the buffer is empty.
- Latency: push → count/empty update on the next cycle.
- Push on full:
  - TX: write dropped, no other effect.
  - RX, FIFO mode: character dropped, overrun set.
  - RX, holding mode: RBR overwritten, overrun set.
- Pop on empty: ignored.
- Simultaneous push and pop:
  - Not full and not empty: both happen, count unchanged.
  - Full: pop frees the slot, so the push is accepted with no overrun.
  - Empty: push only.
- Pointers wrap modulo DEPTH. Counts are DEPTH_LOG+1 bits wide and reach exactly DEPTH.
- Clear: txclr/rxclr empties the respective buffer the next cycle and overrides a same-cycle push or pop.
  - rxclr also zeroes the error counter and the timeout state. It does not clear overrun.
- Mode change: on any cycle where fifoen differs from its registered copy, both buffers are cleared as if txclr and rxclr were asserted.
- Trigger levels: rxfiftl 00 → 1, 01 → DEPTH/4, 10 → DEPTH/2, 11 → DEPTH−2.
  - FIFO mode: rx_trigger = fifoen & (rx_count >= level).
  - Holding mode: rx_trigger = ~rx_empty.
- Error flag: an internal counter (DEPTH_LOG+1 bits) tracks stored entries with a nonzero error field.
  - +1 on an accepted errored push; −1 on popping an errored head; both in the same cycle leave it unchanged.
  - rx_fifo_err = (counter != 0).
- Overrun: set has priority over ovr_clr in the same cycle.

Optional Feature:
Macro: UART_BUF_TIMEOUT_EN.
- Enabled: a saturating counter increments on char_tick while fifoen = 1, RX is not empty, and neither receive_done nor rbr_rd_en is active.
  - The counter resets to 0 on receive_done, rbr_rd_en, rxclr, or RX empty.
  - rx_timeout = 1 while counter >= TO_CHARS.
- Disabled: no counter is built. rx_timeout is tied to 0 and char_tick is unused.

Test Plan:
- fifoen = 1: push 0x11..0x20 (16 chars) into TX → tx_full = 1, tx_count = 16; a 17th push of 0xAA is dropped; 16 tsr_load pops return 0x11..0x20 in order, then tx_empty = 1.
- fifoen = 1, rxfiftl = 01: receive 3 chars → rx_trigger = 0; 4th char → rx_trigger = 1 the next cycle; one pop → rx_trigger = 0.
- fifoen = 1: fill RX to 16, then receive_done with 0x55 → overrun = 1 and rx_count stays 16; repeat with a same-cycle rbr_rd_en → accepted, no overrun, 0x55 appears last.
- fifoen = 0: receive 0x3C, then 0x4D without a read → rbr = {000, 0x4D}, overrun = 1; ovr_clr → overrun = 0; toggle fifoen → rx_empty = tx_empty = 1.
- Receive chars 0x01 (frame error), 0x02, 0x03 → rx_fifo_err = 1; pop once → rx_fifo_err = 0; rxclr with a same-cycle push → rx_count = 0.
- UART_BUF_TIMEOUT_EN, TO_CHARS = 4: 2 chars stored, then 4 char_ticks with no activity → rx_timeout = 1; rbr_rd_en → rx_timeout = 0 the next cycle; assert presetn low mid-count → all flags 0 immediately.
